// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
//   Shared definitions for the clock-divider configuration sequencer:
//   FSM state encodings, channel-select constants, default and minimum
//   divide ratios, and the ratio legality check used by the controller.
//   No ports (package).
// ---------------------------------------------------------------------------
package clk_div_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHECK     = 3'd1;
  localparam logic [2:0] WAIT_EDGE = 3'd2;
  localparam logic [2:0] FORCE     = 3'd3;
  localparam logic [2:0] APPLY     = 3'd4;

  localparam logic CH_ODD  = 1'b0;
  localparam logic CH_EVEN = 1'b1;

  localparam int DEF_ODD_RATIO  = 5;
  localparam int DEF_EVEN_RATIO = 6;
  localparam int MIN_ODD_RATIO  = 3;
  localparam int MIN_EVEN_RATIO = 2;

  // The odd divider only produces a symmetric output for odd ratios of at
  // least 3; the even divider needs an even ratio of at least 2. The ratio
  // is passed zero-extended to 32 bits so one function serves any width.
  function automatic logic ratio_ok(input logic sel, input logic [31:0] v);
    if (sel == CH_ODD) begin
      return v[0] && (v >= 32'(MIN_ODD_RATIO));
    end
    return !v[0] && (v >= 32'(MIN_EVEN_RATIO));
  endfunction

endpackage

// File: rtl/clk_div_edge_watch.sv
// ---------------------------------------------------------------------------
// clk_div_edge_watch
//   Watches the divided output of the selected channel for a rising edge
//   and counts how long the controller has been waiting for one.
//   Ports:
//     clk_i           system clock
//     rst_i           synchronous active-high reset
//     sel_i           channel being watched (CH_ODD / CH_EVEN)
//     clk_out_odd_i   odd divider output
//     clk_out_even_i  even divider output
//     start_i         clears the wait counter before a new wait begins
//     en_i            high while the controller is waiting for an edge
//     edge_seen_o     rising edge on the selected output this cycle
//     timed_out_o     wait counter has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module clk_div_edge_watch
  import clk_div_pkg::*;
#(
  parameter int TIMEOUT = 8192
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sel_i,
  input  logic clk_out_odd_i,
  input  logic clk_out_even_i,
  input  logic start_i,
  input  logic en_i,
  output logic edge_seen_o,
  output logic timed_out_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic          out_sel;
  logic          out_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign out_sel = (sel_i == CH_EVEN) ? clk_out_even_i : clk_out_odd_i;

  // The previous sample of the selected output is kept every cycle, so it
  // is already valid on the first waiting cycle and an edge arriving right
  // then is not missed.
  assign edge_seen_o = en_i && out_sel && !out_q;
  assign timed_out_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  // The counter holds once the limit is reached; the controller leaves the
  // wait on that same cycle, so it never needs to wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (en_i && !timed_out_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output history and wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_sel;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_cfg_ctrl
//   Configuration sequencer for the odd/even clock divider channels. Takes
//   ratio writes over a valid/ready port, rejects illegal ratios, and swaps
//   a new ratio in only at a rising edge of that channel's divided output.
//   If the channel never produces an edge, the divider is reset for RST_CYC
//   cycles and the ratio is applied anyway.
//   Ports:
//     clk_in, rst                   clock, synchronous active-high reset
//     cfg_valid/cfg_ready           request handshake
//     cfg_sel, cfg_div              target channel and requested ratio
//     cfg_done, cfg_err, cfg_tmo    result pulses (tmo accompanies done)
//     clk_out_odd, clk_out_even     divided outputs fed back from divider
//     div_odd, div_even             active ratios driven to the divider
//     div_rst                       divider reset for the forced update
// ---------------------------------------------------------------------------
module clk_div_cfg_ctrl
  import clk_div_pkg::*;
#(
  parameter int W        = 12,
  parameter int DEF_ODD  = DEF_ODD_RATIO,
  parameter int DEF_EVEN = DEF_EVEN_RATIO,
  parameter int TIMEOUT  = 8192,
  parameter int RST_CYC  = 2
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic         cfg_sel,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_done,
  output logic         cfg_err,
  output logic         cfg_tmo,
  input  logic         clk_out_odd,
  input  logic         clk_out_even,
  output logic [W-1:0] div_odd,
  output logic [W-1:0] div_even,
  output logic         div_rst
);

  localparam int RW = $clog2(RST_CYC + 1);

  logic [2:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic [W-1:0]  val_q, val_d;
  logic [W-1:0]  div_odd_q, div_odd_d;
  logic [W-1:0]  div_even_q, div_even_d;
  logic          forced_q, forced_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          ready_q, done_q, done_d, err_q, err_d, tmo_q, tmo_d, div_rst_q;
  logic [W-1:0]  cur_ratio;
  logic          watch_start;
  logic          edge_seen;
  logic          timed_out;

  assign cur_ratio = (sel_q == CH_EVEN) ? div_even_q : div_odd_q;

  clk_div_edge_watch #(
    .TIMEOUT (TIMEOUT)
  ) u_watch (
    .clk_i          (clk_in),
    .rst_i          (rst),
    .sel_i          (sel_q),
    .clk_out_odd_i  (clk_out_odd),
    .clk_out_even_i (clk_out_even),
    .start_i        (watch_start),
    .en_i           (state_q == WAIT_EDGE),
    .edge_seen_o    (edge_seen),
    .timed_out_o    (timed_out)
  );

  // Sequencer: capture a request, validate it, then wait for a clean edge
  // (or force one via divider reset) before the ratio is swapped in APPLY.
  // A request equal to the active ratio skips the wait since nothing on the
  // divider changes. An edge beats a simultaneous timeout.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    val_d       = val_q;
    div_odd_d   = div_odd_q;
    div_even_d  = div_even_q;
    forced_d    = forced_q;
    rcnt_d      = rcnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    tmo_d       = 1'b0;
    watch_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid && ready_q) begin
          sel_d    = cfg_sel;
          val_d    = cfg_div;
          forced_d = 1'b0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (!ratio_ok(sel_q, 32'(val_q))) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (val_q == cur_ratio) begin
          state_d = APPLY;
        end else begin
          watch_start = 1'b1;
          state_d     = WAIT_EDGE;
        end
      end
      WAIT_EDGE: begin
        if (edge_seen) begin
          state_d = APPLY;
        end else if (timed_out) begin
          forced_d = 1'b1;
          rcnt_d   = '0;
          state_d  = FORCE;
        end
      end
      FORCE: begin
        if (rcnt_q == RW'(RST_CYC - 1)) begin
          state_d = APPLY;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      APPLY: begin
        if (sel_q == CH_EVEN) begin
          div_even_d = val_q;
        end else begin
          div_odd_d = val_q;
        end
        done_d  = 1'b1;
        tmo_d   = forced_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs come straight from flops. Ready and div_rst are derived
  // from the next state so they line up with the cycles spent in IDLE and
  // FORCE respectively.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= CH_ODD;
      val_q      <= '0;
      div_odd_q  <= W'(DEF_ODD);
      div_even_q <= W'(DEF_EVEN);
      forced_q   <= 1'b0;
      rcnt_q     <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      div_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      val_q      <= val_d;
      div_odd_q  <= div_odd_d;
      div_even_q <= div_even_d;
      forced_q   <= forced_d;
      rcnt_q     <= rcnt_d;
      ready_q    <= (state_d == IDLE);
      done_q     <= done_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      div_rst_q  <= (state_d == FORCE);
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign cfg_tmo   = tmo_q;
  assign div_odd   = div_odd_q;
  assign div_even  = div_even_q;
  assign div_rst   = div_rst_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_cfg_ctrl
//   Scenario bench for the divider configuration sequencer. The divider
//   feedback outputs are driven directly so edge timing is exact. Expected
//   results are queued when a request is issued and popped when the DUT
//   pulses cfg_done or cfg_err.
// ---------------------------------------------------------------------------
module tb_clk_div_cfg_ctrl;

  localparam int W       = 12;
  localparam int TIMEOUT = 16;
  localparam int RST_CYC = 2;
  localparam logic [W-1:0] EXP_DEF_ODD  = 12'd5;
  localparam logic [W-1:0] EXP_DEF_EVEN = 12'd6;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_sel = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         clk_out_odd = 1'b0;
  logic         clk_out_even = 1'b0;
  logic         cfg_ready, cfg_done, cfg_err, cfg_tmo, div_rst;
  logic [W-1:0] div_odd, div_even;

  typedef struct {
    bit           is_err;
    bit           tmo;
    logic [W-1:0] odd;
    logic [W-1:0] even;
  } exp_t;

  exp_t         expq[$];
  exp_t         e;
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] modelOdd = EXP_DEF_ODD;
  logic [W-1:0] modelEven = EXP_DEF_EVEN;

  clk_div_cfg_ctrl #(
    .W        (W),
    .DEF_ODD  (5),
    .DEF_EVEN (6),
    .TIMEOUT  (TIMEOUT),
    .RST_CYC  (RST_CYC)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_sel      (cfg_sel),
    .cfg_div      (cfg_div),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .cfg_tmo      (cfg_tmo),
    .clk_out_odd  (clk_out_odd),
    .clk_out_even (clk_out_even),
    .div_odd      (div_odd),
    .div_even     (div_even),
    .div_rst      (div_rst)
  );

  // Free-running system clock.
  always #5 clk_in = ~clk_in;

  // Hard stop in case a scenario wedges somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one request. Entered and left just after a rising edge.
  task automatic send(input logic sel, input logic [W-1:0] v);
    int n;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(posedge clk_in); #1;
      n++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_wait: cfg_ready=%b, required 1", cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_div   = v;
    @(posedge clk_in); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      checks++;
      if ({div_odd, div_even, cfg_ready, cfg_done, cfg_err, cfg_tmo, div_rst} !==
          {EXP_DEF_ODD, EXP_DEF_EVEN, 5'b00000}) begin
        failures++;
        $display("[TB] FAIL reset_values: odd=%0d even=%0d rdy/done/err/tmo/rst=%b%b%b%b%b, required 5 6 00000",
                 div_odd, div_even, cfg_ready, cfg_done, cfg_err, cfg_tmo, div_rst);
      end
    end
    @(posedge clk_in); #1;
    rst = 1'b0;
    @(negedge clk_in);
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_in_reset_cycle: cfg_ready=%b, required 0", cfg_ready);
    end
    @(negedge clk_in);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_reset: cfg_ready=%b, required 1", cfg_ready);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_same_value();
    int lat;
    bit sawRst;
    expq.push_back('{is_err: 1'b0, tmo: 1'b0, odd: modelOdd, even: modelEven});
    send(1'b0, 12'd5);
    sawRst = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk_in);
      lat++;
      if (div_rst === 1'b1) sawRst = 1'b1;
      if (cfg_done === 1'b1 || cfg_err === 1'b1) break;
    end
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("[TB] FAIL same_latency: result after %0d cycles, required 3", lat);
    end
    checks++;
    if (sawRst) begin
      failures++;
      $display("[TB] FAIL same_div_rst: div_rst=1 seen, required 0");
    end
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("[TB] FAIL same_result: queue empty, required one entry");
    end else begin
      e = expq.pop_front();
      if ({cfg_done, cfg_err, cfg_tmo, div_odd, div_even} !== {~e.is_err, e.is_err, e.tmo, e.odd, e.even}) begin
        failures++;
        $display("[TB] FAIL same_result: done/err/tmo=%b%b%b odd=%0d even=%0d, required %b%b%b odd=%0d even=%0d",
                 cfg_done, cfg_err, cfg_tmo, div_odd, div_even, ~e.is_err, e.is_err, e.tmo, e.odd, e.even);
      end
    end
    @(negedge clk_in);
    checks++;
    if (cfg_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL same_done_pulse: cfg_done=%b a cycle later, required 0", cfg_done);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_legal_odd();
    int lat;
    bit early;
    modelOdd = 12'd7;
    expq.push_back('{is_err: 1'b0, tmo: 1'b0, odd: modelOdd, even: modelEven});
    send(1'b0, 12'd7);
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      if (i == 0) begin
        checks++;
        if (cfg_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL legal_ready_drop: cfg_ready=%b after accept, required 0", cfg_ready);
        end
      end
      if (div_odd !== EXP_DEF_ODD || cfg_done !== 1'b0) early = 1'b1;
      @(posedge clk_in); #1;
      clk_out_even = 1'b1;
    end
    clk_out_odd = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk_in);
      lat++;
      if (cfg_done === 1'b1 || cfg_err === 1'b1) break;
      if (div_odd !== EXP_DEF_ODD || div_rst !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("[TB] FAIL legal_hold: ratio/done/div_rst changed before edge apply, required odd=5 until done");
    end
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("[TB] FAIL legal_latency: done %0d cycles after edge, required 3", lat);
    end
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("[TB] FAIL legal_result: queue empty, required one entry");
    end else begin
      e = expq.pop_front();
      if ({cfg_done, cfg_err, cfg_tmo, div_odd, div_even} !== {~e.is_err, e.is_err, e.tmo, e.odd, e.even}) begin
        failures++;
        $display("[TB] FAIL legal_result: done/err/tmo=%b%b%b odd=%0d even=%0d, required %b%b%b odd=%0d even=%0d",
                 cfg_done, cfg_err, cfg_tmo, div_odd, div_even, ~e.is_err, e.is_err, e.tmo, e.odd, e.even);
      end
    end
    @(negedge clk_in);
    checks++;
    if (cfg_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL legal_done_pulse: cfg_done=%b a cycle later, required 0", cfg_done);
    end
    @(posedge clk_in); #1;
    clk_out_odd  = 1'b0;
    clk_out_even = 1'b0;
  endtask

  task automatic test_illegal();
    logic         selTab[3];
    logic [W-1:0] valTab[3];
    int           lat;
    selTab = '{1'b0, 1'b0, 1'b1};
    valTab = '{12'd4, 12'd1, 12'd9};
    for (int k = 0; k < 3; k++) begin
      expq.push_back('{is_err: 1'b1, tmo: 1'b0, odd: modelOdd, even: modelEven});
      send(selTab[k], valTab[k]);
      lat = 0;
      while (lat < 10) begin
        @(negedge clk_in);
        lat++;
        if (cfg_done === 1'b1 || cfg_err === 1'b1) break;
      end
      checks++;
      if (lat !== 2) begin
        failures++;
        $display("[TB] FAIL illegal_latency[%0d]: err after %0d cycles, required 2", k, lat);
      end
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("[TB] FAIL illegal_result[%0d]: queue empty, required one entry", k);
      end else begin
        e = expq.pop_front();
        if ({cfg_done, cfg_err, cfg_tmo, div_odd, div_even} !== {~e.is_err, e.is_err, e.tmo, e.odd, e.even}) begin
          failures++;
          $display("[TB] FAIL illegal_result[%0d]: done/err/tmo=%b%b%b odd=%0d even=%0d, required %b%b%b odd=%0d even=%0d",
                   k, cfg_done, cfg_err, cfg_tmo, div_odd, div_even, ~e.is_err, e.is_err, e.tmo, e.odd, e.even);
        end
      end
      @(posedge clk_in); #1;
    end
  endtask

  task automatic test_stall();
    int lat;
    int rstCycles;
    bit early;
    clk_out_even = 1'b0;
    modelEven = 12'd8;
    expq.push_back('{is_err: 1'b0, tmo: 1'b1, odd: modelOdd, even: modelEven});
    send(1'b1, 12'd8);
    lat = 0;
    rstCycles = 0;
    early = 1'b0;
    while (lat < 60) begin
      @(negedge clk_in);
      lat++;
      if (div_rst === 1'b1) rstCycles++;
      if (cfg_done === 1'b1 || cfg_err === 1'b1) break;
      if (div_even !== EXP_DEF_EVEN || div_odd !== modelOdd) early = 1'b1;
    end
    checks++;
    if (lat !== 1 + TIMEOUT + RST_CYC + 2) begin
      failures++;
      $display("[TB] FAIL stall_latency: done after %0d cycles, required %0d", lat, 1 + TIMEOUT + RST_CYC + 2);
    end
    checks++;
    if (rstCycles !== RST_CYC) begin
      failures++;
      $display("[TB] FAIL stall_div_rst: div_rst high %0d cycles, required %0d", rstCycles, RST_CYC);
    end
    checks++;
    if (early) begin
      failures++;
      $display("[TB] FAIL stall_hold: ratios changed before forced apply, required odd=%0d even=6", modelOdd);
    end
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("[TB] FAIL stall_result: queue empty, required one entry");
    end else begin
      e = expq.pop_front();
      if ({cfg_done, cfg_err, cfg_tmo, div_odd, div_even} !== {~e.is_err, e.is_err, e.tmo, e.odd, e.even}) begin
        failures++;
        $display("[TB] FAIL stall_result: done/err/tmo=%b%b%b odd=%0d even=%0d, required %b%b%b odd=%0d even=%0d",
                 cfg_done, cfg_err, cfg_tmo, div_odd, div_even, ~e.is_err, e.is_err, e.tmo, e.odd, e.even);
      end
    end
    @(negedge clk_in);
    checks++;
    if ({cfg_done, cfg_tmo, div_rst} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL stall_after: done/tmo/div_rst=%b%b%b, required 000", cfg_done, cfg_tmo, div_rst);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset_mid_wait();
    int pulses;
    clk_out_even = 1'b0;
    send(1'b1, 12'd10);
    repeat (4) begin
      @(posedge clk_in); #1;
    end
    rst = 1'b1;
    @(posedge clk_in); #1;
    rst = 1'b0;
    modelOdd  = EXP_DEF_ODD;
    modelEven = EXP_DEF_EVEN;
    @(negedge clk_in);
    checks++;
    if ({div_odd, div_even, cfg_ready} !== {modelOdd, modelEven, 1'b0}) begin
      failures++;
      $display("[TB] FAIL midwait_reset: odd=%0d even=%0d ready=%b, required 5 6 0", div_odd, div_even, cfg_ready);
    end
    @(negedge clk_in);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midwait_ready: cfg_ready=%b, required 1", cfg_ready);
    end
    pulses = 0;
    for (int i = 0; i < 2 * TIMEOUT + 8; i++) begin
      @(posedge clk_in); #1;
      clk_out_even = ~clk_out_even;
      @(negedge clk_in);
      if (cfg_done === 1'b1 || cfg_err === 1'b1 || div_rst === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || div_even !== modelEven) begin
      failures++;
      $display("[TB] FAIL midwait_discard: %0d done/err/div_rst cycles, even=%0d, required 0 and 6", pulses, div_even);
    end
    checks++;
    if (expq.size() !== 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", expq.size());
    end
    @(posedge clk_in); #1;
    clk_out_even = 1'b0;
  endtask

  // Scenarios run in order; each leaves the DUT idle just after a rising edge.
  initial begin
    test_reset();
    test_same_value();
    test_legal_odd();
    test_illegal();
    test_stall();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
